// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master with runtime CPOL/CPHA and NUM_SS active-low selects.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first bit order on mosi and miso (default MSB first).
module spi_master_param #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned NUM_SS   = 1,
   localparam int unsigned SS_IDX_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tx_en,
   input  logic [DATA_W-1:0]   p_dat,
   input  logic [SS_IDX_W-1:0] ss_idx,
   input  logic [1:0]          mode,
   input  logic                miso,
   output logic                mosi,
   output logic                sclk,
   output logic [NUM_SS-1:0]   ss,
   output logic                busy,
   output logic                done,
   output logic [DATA_W-1:0]   rx_dat
);

   localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned EDGE_W = $clog2(2 * DATA_W);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} state_e;

   state_e              state_q, state_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
   logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
   logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
   logic [DATA_W-1:0]   rx_dat_q, rx_dat_d;
   logic                cpol_q, cpol_d;
   logic                cpha_q, cpha_d;
   logic                sclk_q, sclk_d;
   logic                mosi_q, mosi_d;
   logic [NUM_SS-1:0]   ss_q, ss_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                evt;
   logic [EDGE_W-1:0]   evt_k;

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      edge_cnt_d = edge_cnt_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      rx_dat_d   = rx_dat_q;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      ss_d       = ss_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      evt        = 1'b0;
      evt_k      = '0;

      case (state_q)
         StIdle: begin
            ss_d   = '1;
            mosi_d = 1'b0;
            sclk_d = cpol_q;
            cpol_d = mode[1];
            busy_d = 1'b0;
            div_d  = '0;
            if (tx_en) begin
               state_d = StSetup;
               tx_sh_d = p_dat;
               cpha_d  = mode[0];
               sclk_d  = mode[1];
               busy_d  = 1'b1;
`ifdef SPI_MASTER_LSB_FIRST_EN
               mosi_d  = p_dat[0];
`else
               mosi_d  = p_dat[DATA_W-1];
`endif
               // Out-of-range index leaves every select deasserted.
               for (int unsigned i = 0; i < NUM_SS; i++) begin
                  if (ss_idx == SS_IDX_W'(i)) ss_d[i] = 1'b0;
               end
            end
         end
         StSetup: begin
            div_d = div_q + 1'b1;
            if (div_q == DIV_LAST) begin
               div_d      = '0;
               state_d    = StXfer;
               edge_cnt_d = '0;
               sclk_d     = ~sclk_q;
               evt        = 1'b1;
               evt_k      = '0;
            end
         end
         StXfer: begin
            div_d = div_q + 1'b1;
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (edge_cnt_q == EDGE_LAST) begin
                  state_d = StHold;
               end else begin
                  edge_cnt_d = edge_cnt_q + 1'b1;
                  sclk_d     = ~sclk_q;
                  evt        = 1'b1;
                  evt_k      = edge_cnt_q + 1'b1;
               end
            end
         end
         StHold: begin
            div_d = div_q + 1'b1;
            if (div_q == DIV_LAST) begin
               div_d    = '0;
               state_d  = StIdle;
               done_d   = 1'b1;
               rx_dat_d = rx_sh_q;
               busy_d   = 1'b0;
               ss_d     = '1;
               mosi_d   = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase

      // Even edge numbers are leading edges; sample when the edge type differs from CPHA.
      if (evt) begin
         if (~evt_k[0] != cpha_q) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
            rx_sh_d = {miso, rx_sh_q[DATA_W-1:1]};
`else
            rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
`endif
         end else if (evt_k != '0 && evt_k != EDGE_LAST) begin
            // Edge 0 (CPHA=1) re-presents the bit already driven in SETUP.
`ifdef SPI_MASTER_LSB_FIRST_EN
            tx_sh_d = tx_sh_q >> 1;
            mosi_d  = tx_sh_q[1];
`else
            tx_sh_d = tx_sh_q << 1;
            mosi_d  = tx_sh_q[DATA_W-2];
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         div_q      <= '0;
         edge_cnt_q <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         rx_dat_q   <= '0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         ss_q       <= '1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         edge_cnt_q <= edge_cnt_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         rx_dat_q   <= rx_dat_d;
         cpol_q     <= cpol_d;
         cpha_q     <= cpha_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         ss_q       <= ss_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign mosi   = mosi_q;
   assign sclk   = sclk_q;
   assign ss     = ss_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign rx_dat = rx_dat_q;

endmodule
